// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between icache and dcache miss paths, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_W-1:0]     ic_req_addr,
  output logic                  ic_resp_valid,
  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic                  dc_req_rnw,
  input  logic [ADDR_W-1:0]     dc_req_addr,
  input  logic [DATA_W-1:0]     dc_req_data,
  input  logic [DATA_W/8-1:0]   dc_req_mask,
  output logic                  dc_resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rnw,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [DATA_W/8-1:0]   mem_req_mask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                state_r;
  logic                  owner_dc_r;
  logic                  rnw_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     data_r;
  logic [DATA_W/8-1:0]   mask_r;
  logic                  mem_req_valid_r;
  logic                  busy_r;
  logic                  ic_resp_valid_r;
  logic                  dc_resp_valid_r;
  logic [DATA_W-1:0]     resp_data_r;
  logic                  grant_ic_s;
  logic                  grant_dc_s;
`ifdef ARB_RR_EN
  logic                  last_grant_dc_r;
`endif

  // Grant selection in IDLE; readies are held low while reset is asserted.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if ((state_r == ST_IDLE) && reset) begin
`ifdef ARB_RR_EN
      if (dc_req_valid && (!ic_req_valid || !last_grant_dc_r)) begin
        grant_dc_s = 1'b1;
      end else if (ic_req_valid) begin
        grant_ic_s = 1'b1;
      end else begin
        grant_dc_s = 1'b0;
      end
`else
      if (dc_req_valid) begin
        grant_dc_s = 1'b1;
      end else if (ic_req_valid) begin
        grant_ic_s = 1'b1;
      end else begin
        grant_dc_s = 1'b0;
      end
`endif
    end else begin
      grant_ic_s = 1'b0;
    end
  end

  assign ic_req_ready = grant_ic_s;
  assign dc_req_ready = grant_dc_s;

  // Transaction FSM with registered memory request, response and busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      owner_dc_r      <= 1'b0;
      rnw_r           <= 1'b0;
      addr_r          <= {ADDR_W{1'b0}};
      data_r          <= {DATA_W{1'b0}};
      mask_r          <= {(DATA_W/8){1'b0}};
      mem_req_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
      resp_data_r     <= {DATA_W{1'b0}};
`ifdef ARB_RR_EN
      last_grant_dc_r <= 1'b0;
`endif
    end else begin
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_dc_s) begin
            owner_dc_r      <= 1'b1;
            rnw_r           <= dc_req_rnw;
            addr_r          <= dc_req_addr;
            data_r          <= dc_req_data;
            mask_r          <= dc_req_mask;
            mem_req_valid_r <= 1'b1;
            busy_r          <= 1'b1;
            state_r         <= ST_ISSUE;
`ifdef ARB_RR_EN
            last_grant_dc_r <= 1'b1;
`endif
          end else if (grant_ic_s) begin
            owner_dc_r      <= 1'b0;
            rnw_r           <= 1'b1;
            addr_r          <= ic_req_addr;
            data_r          <= {DATA_W{1'b0}};
            mask_r          <= {(DATA_W/8){1'b0}};
            mem_req_valid_r <= 1'b1;
            busy_r          <= 1'b1;
            state_r         <= ST_ISSUE;
`ifdef ARB_RR_EN
            last_grant_dc_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            if (rnw_r) begin
              state_r <= ST_WAIT;
            end else begin
              // Only the dcache writes, so the write ack always goes to it.
              state_r         <= ST_IDLE;
              busy_r          <= 1'b0;
              dc_resp_valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            resp_data_r <= mem_resp_data;
            if (owner_dc_r) begin
              dc_resp_valid_r <= 1'b1;
            end else begin
              ic_resp_valid_r <= 1'b1;
            end
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          busy_r          <= 1'b0;
          mem_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ic_resp_valid = ic_resp_valid_r;
  assign dc_resp_valid = dc_resp_valid_r;
  assign resp_data     = resp_data_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_rnw   = rnw_r;
  assign mem_req_addr  = addr_r;
  assign mem_req_data  = data_r;
  assign mem_req_mask  = mask_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a monitor pops them on resp pulses.
module tb_mem_arbiter;

  logic          clk;
  logic          reset;
  logic          ic_req_valid;
  logic          ic_req_ready;
  logic [27:0]   ic_req_addr;
  logic          ic_resp_valid;
  logic          dc_req_valid;
  logic          dc_req_ready;
  logic          dc_req_rnw;
  logic [27:0]   dc_req_addr;
  logic [127:0]  dc_req_data;
  logic [15:0]   dc_req_mask;
  logic          dc_resp_valid;
  logic [127:0]  resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rnw;
  logic [27:0]   mem_req_addr;
  logic [127:0]  mem_req_data;
  logic [15:0]   mem_req_mask;
  logic          mem_resp_valid;
  logic [127:0]  mem_resp_data;
  logic          busy;

  typedef struct packed {
    logic         dc;
    logic [127:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [127:0]  last_data = 128'h0;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rnw(dc_req_rnw),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
    .dc_resp_valid(dc_resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, mem_req_valid,
                 mem_req_rnw, busy, mem_req_addr, mem_req_data, mem_req_mask}, 256'h0);
    check({name, "_resp_data"}, resp_data, 256'h0);
  endtask

  // Waits for a grant, checks who got it, and completes the handshake.
  task automatic wait_accept(input logic exp_dc);
    int   n;
    logic got_dc;
    n = 0;
    #1;
    while (!ic_req_ready && !dc_req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ic_req_ready && !dc_req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no grant expected a grant within 20 cycles");
    end else begin
      got_dc = dc_req_ready;
      check("grant_dc", got_dc, exp_dc);
      tick();
      if (got_dc) dc_req_valid = 1'b0;
      else ic_req_valid = 1'b0;
    end
  endtask

  // Plays the memory side: checks the request, stalls, accepts, and answers reads after lat cycles.
  task automatic serve(input logic rnw, input logic [27:0] addr, input logic [127:0] wdata,
                       input logic [15:0] wmask, input int stall, input int lat,
                       input logic [127:0] rdata);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("issue_latency", n, 0);
    check("mem_req", {mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask},
          {1'b1, rnw, addr, wdata, wmask});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_hold", {mem_req_valid, busy, ic_req_ready, dc_req_ready,
                           mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask},
            {1'b1, 1'b1, 1'b0, 1'b0, rnw, addr, wdata, wmask});
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if (!rnw) begin
      check("write_no_wait", {busy, mem_req_valid}, 2'b00);
    end else begin
      check("wait_busy", {busy, mem_req_valid}, 2'b10);
      if (lat > 0) begin
        repeat (lat - 1) tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
      end
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ic_resp_valid || dc_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got ic=%0b dc=%0b data=%0h expected no pulse",
                   ic_resp_valid, dc_resp_valid, resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp", {ic_resp_valid, dc_resp_valid, resp_data}, {~e.dc, e.dc, e.data});
        end
      end
    end
  end

  initial begin
    logic [127:0] d;
    reset = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = 28'h0;
    dc_req_valid = 1'b0; dc_req_rnw = 1'b1; dc_req_addr = 28'h0;
    dc_req_data = 128'h0; dc_req_mask = 16'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 128'h0;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    reset = 1'b1;
    tick();

    // icache read with two-cycle memory latency
    d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000100;
    wait_accept(1'b0);
    exp_q.push_back({1'b0, d}); last_data = d;
    serve(1'b1, 28'h0000100, 128'h0, 16'h0, 0, 2, d);

    // two rounds of simultaneous reads: D, I, D, I
    for (int r = 0; r < 2; r++) begin
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000200 + 28'(r);
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 28'h0000300 + 28'(r);
      wait_accept(1'b1);
      d = 128'h11111111_22222222_33333333_00000000 + 128'(r);
      exp_q.push_back({1'b1, d}); last_data = d;
      serve(1'b1, 28'h0000300 + 28'(r), 128'h0, 16'h0, 0, 1, d);
      wait_accept(1'b0);
      d = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_00000000 + 128'(r);
      exp_q.push_back({1'b0, d}); last_data = d;
      serve(1'b1, 28'h0000200 + 28'(r), 128'h0, 16'h0, 0, 3, d);
    end

    // dcache write with memory stalling for five cycles
    dc_req_valid = 1'b1; dc_req_rnw = 1'b0; dc_req_addr = 28'h000002A;
    dc_req_data = 128'h01234567_89ABCDEF_FEDCBA98_76543210; dc_req_mask = 16'h00FF;
    wait_accept(1'b1);
    exp_q.push_back({1'b1, last_data});
    serve(1'b0, 28'h000002A, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'h00FF, 5, 0, 128'h0);
    dc_req_rnw = 1'b1; dc_req_data = 128'h0; dc_req_mask = 16'h0;

    // tie right after a dcache grant: round-robin favours the icache
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000400;
    dc_req_valid = 1'b1; dc_req_addr = 28'h0000500;
`ifdef ARB_RR_EN
    wait_accept(1'b0);
    d = 128'h44444444_44444444_44444444_44444444;
    exp_q.push_back({1'b0, d}); last_data = d;
    serve(1'b1, 28'h0000400, 128'h0, 16'h0, 0, 1, d);
    wait_accept(1'b1);
    d = 128'h55555555_55555555_55555555_55555555;
    exp_q.push_back({1'b1, d}); last_data = d;
    serve(1'b1, 28'h0000500, 128'h0, 16'h0, 0, 1, d);
`else
    wait_accept(1'b1);
    d = 128'h55555555_55555555_55555555_55555555;
    exp_q.push_back({1'b1, d}); last_data = d;
    serve(1'b1, 28'h0000500, 128'h0, 16'h0, 0, 1, d);
    wait_accept(1'b0);
    d = 128'h44444444_44444444_44444444_44444444;
    exp_q.push_back({1'b0, d}); last_data = d;
    serve(1'b1, 28'h0000400, 128'h0, 16'h0, 0, 1, d);
`endif

    // stray memory response while idle is ignored
    mem_resp_valid = 1'b1; mem_resp_data = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    tick();
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = 128'h0;
    tick();
    check("idle_resp_data", resp_data, last_data);
    check("idle_busy", busy, 1'b0);

    // reset asserted while waiting for read data
    dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 28'h000003C;
    wait_accept(1'b1);
    serve(1'b1, 28'h000003C, 128'h0, 16'h0, 0, 0, 128'h0);
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_in_wait");
    tick();
    reset = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 128'h99999999_99999999_99999999_99999999;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = 128'h0;
    tick();
    tick();
    check_outputs_zero("after_reset");
    last_data = 128'h0;

    // normal read after reset recovery
    ic_req_valid = 1'b1; ic_req_addr = 28'h00007FF;
    wait_accept(1'b0);
    d = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
    exp_q.push_back({1'b0, d}); last_data = d;
    serve(1'b1, 28'h00007FF, 128'h0, 16'h0, 0, 2, d);
    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
